rom_download_sequencer: RTL and testbench
=========================================

Name: rom_download_sequencer

Overview:
- Front-end stage between the HPS ioctl download stream and the ROM address selector / per-EPROM dual-port RAMs.
- Qualifies the ioctl stream by index, registers address and data, and emits a clean one-cycle write strobe to the selector and EPROM write ports.
- Tracks byte count, 16-bit checksum and out-of-range writes.
- Holds the core in reset during download and for a settle period afterwards, then flags ROM ready or short.

Parameters:
- ROM_INDEX, 0, ioctl_index value accepted as ROM data.
- ROM_SIZE, 'h1C100, total expected bytes; addresses >= ROM_SIZE are dropped.
- SETTLE_CYCLES, 16, cycles core_reset stays high after download ends (1..65535).

Ports:
- CLK  in  1  system/download clock (single domain).
- RESET_N  in  1  synchronous, active-low reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  byte write strobe, single cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- dl_addr  out  25  registered address to selector / ADDR_DL.
- dl_data  out  8  registered data to DATA_IN.
- dl_wr  out  1  one-cycle write strobe (WR).
- core_reset  out  1  high = hold main/sound CPUs in reset.
- rom_ready  out  1  image loaded and settled.
- rom_short  out  1  valid in READY: fewer than ROM_SIZE in-range bytes written.
- rom_overflow  out  1  sticky: a write with address >= ROM_SIZE occurred this load.
- byte_count  out  25  in-range bytes written this load.
- checksum  out  16  sum of in-range bytes mod 2^16.

Behaviour:
- Reset (RESET_N=0 at a CLK edge):
  - State goes to IDLE.
  - dl_addr=0, dl_data=0, dl_wr=0, core_reset=1, rom_ready=0, rom_short=0, rom_overflow=0, byte_count=0, checksum=0, settle counter=0.
  - Reset mid-LOAD aborts the load the same way. No write strobe issues after the reset edge.
- Load start:
  - dl_start = ioctl_download high AND registered previous value low AND ioctl_index==ROM_INDEX.
  - dl_end = registered ioctl_download high AND ioctl_download low.
- FSM states: IDLE, LOAD, SETTLE, READY.
  - IDLE: core_reset=1. On dl_start -> LOAD.
  - LOAD: core_reset=1, rom_ready=0. On dl_end -> SETTLE, settle counter cleared.
  - SETTLE: counter increments each cycle. When counter == SETTLE_CYCLES-1 -> READY.
  - READY: core_reset=0, rom_ready=1. rom_short = (byte_count < ROM_SIZE), registered on entry.
  - From SETTLE or READY, dl_start -> LOAD.
  - A download with any other index is ignored in every state; READY is held.
- On every dl_start: byte_count, checksum and rom_overflow clear, rom_ready=0, core_reset=1, all in the cycle after dl_start.
- Write path (latency 1):
  - Accept condition: ioctl_wr=1, state LOAD (or the dl_start cycle itself), ioctl_index==ROM_INDEX.
  - When ioctl_addr < ROM_SIZE:
    - dl_addr<=ioctl_addr, dl_data<=ioctl_dout, dl_wr<=1 for exactly one cycle.
    - byte_count<=byte_count+1, saturating at 2^25-1.
    - checksum<=checksum+ioctl_dout, wrapping mod 2^16.
  - When ioctl_addr >= ROM_SIZE: no dl_wr, counters unchanged, rom_overflow<=1.
  - dl_addr/dl_data hold their last value when dl_wr=0.
- Simultaneous events:
  - ioctl_wr in the same cycle as dl_end is accepted and counted.
  - ioctl_wr in the dl_start cycle is accepted after the clear, so byte_count=1.
  - Back-to-back writes on consecutive cycles each produce their own dl_wr pulse.
- Duplicate addresses are counted each time. No address-coverage tracking.
- ioctl_wr outside LOAD is ignored. dl_wr stays 0 in IDLE, SETTLE and READY.

Test Plan:
- Reset then idle 10 cycles -> core_reset=1, rom_ready=0, dl_wr never asserted, all counters 0.
- Index 0 download, bytes 0x01,0x02,0xFF at addr 0,1,'h1C0FF, then download low -> three dl_wr pulses, each one cycle after its ioctl_wr with matching addr/data; byte_count=3, checksum='h0102. After 16 settle cycles: core_reset=0, rom_ready=1, rom_short=1.
- Full 'h1C100-byte load of value 0x01, plus one write at 'h1C100 -> byte_count='h1C100, checksum='hC100, rom_overflow=1, rom_short=0, last dl_addr='h1C0FF.
- Download with index 1 while in READY, with writes -> no dl_wr, rom_ready stays 1, counters unchanged.
- RESET_N low for one cycle mid-LOAD at byte 100 -> state IDLE, byte_count=0, dl_wr=0 from the next cycle. Remaining writes are ignored until a new download rising edge.
- Reload from READY; ioctl_wr coincides with the dl_start cycle and with the dl_end cycle -> core_reset=1 the next cycle, both bytes counted, byte_count reflects only the new load.

Source files
------------

// File: rtl/rom_download_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rom_download_sequencer
// Description : Front end between the HPS ioctl download stream and the ROM
//               address selector / per-EPROM dual-port RAMs. Qualifies the
//               stream by index, re-times each accepted byte into a clean
//               one-cycle write strobe, keeps byte count / checksum /
//               out-of-range statistics, and sequences the core reset:
//               held during download and for a settle period afterwards.
// Ports       :
//   CLK            in   1   system / download clock (single domain)
//   RESET_N        in   1   synchronous active-low reset
//   ioctl_download in   1   HPS download active
//   ioctl_index    in   8   download index
//   ioctl_wr       in   1   single-cycle byte write strobe
//   ioctl_addr     in  25   byte address
//   ioctl_dout     in   8   byte data
//   dl_addr        out 25   registered address to selector / ADDR_DL
//   dl_data        out  8   registered data to DATA_IN
//   dl_wr          out  1   one-cycle write strobe (WR)
//   core_reset     out  1   high = hold main/sound CPUs in reset
//   rom_ready      out  1   image loaded and settled
//   rom_short      out  1   in READY: fewer than ROM_SIZE bytes written
//   rom_overflow   out  1   sticky: write at address >= ROM_SIZE this load
//   byte_count     out 25   in-range bytes written this load
//   checksum       out 16   sum of in-range bytes mod 2^16
// Revision    : 1.0 - initial release
// ============================================================================
module rom_download_sequencer #(
    parameter int ROM_INDEX     = 0,
    parameter int ROM_SIZE      = 'h1C100,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        rom_short,
    output logic        rom_overflow,
    output logic [24:0] byte_count,
    output logic [15:0] checksum
);

    localparam logic [7:0]  c_rom_index   = 8'(ROM_INDEX);
    localparam logic [24:0] c_rom_size    = 25'(ROM_SIZE);
    localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);
    localparam logic [24:0] c_count_max   = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_download_d;
    logic [15:0] r_settle_cnt;
    logic [24:0] r_dl_addr;
    logic [7:0]  r_dl_data;
    logic        r_dl_wr;
    logic        r_core_reset;
    logic        r_rom_ready;
    logic        r_rom_short;
    logic        r_rom_overflow;
    logic [24:0] r_byte_count;
    logic [15:0] r_checksum;

    logic        w_index_match;
    logic        w_dl_start;
    logic        w_dl_end;
    logic        w_accept;
    logic        w_in_range;
    logic        w_store;
    logic [24:0] w_count_base;
    logic [24:0] w_count_next;
    logic [15:0] w_sum_base;
    logic [15:0] w_sum_next;
    logic        w_ovf_next;

    // Previous value of ioctl_download for edge detection. This register
    // deliberately keeps tracking the input while RESET_N is low: if reset
    // lands in the middle of a download, the still-high download line must
    // not look like a fresh rising edge once reset releases, so the rest of
    // that aborted transfer is ignored until the HPS starts a new one.
    always_ff @(posedge CLK) begin
        r_download_d <= ioctl_download;
    end

    // ------------------------------------------------------------------
    // Stream qualification
    // ------------------------------------------------------------------
    assign w_index_match = (ioctl_index == c_rom_index);
    assign w_dl_start    = ioctl_download & ~r_download_d & w_index_match;
    assign w_dl_end      = r_download_d & ~ioctl_download;

    // The dl_start cycle itself accepts a write so that a byte arriving
    // together with the rising download edge is not lost.
    assign w_accept   = ioctl_wr & w_index_match &
                        ((r_state == ST_LOAD) | w_dl_start);
    assign w_in_range = (ioctl_addr < c_rom_size);
    assign w_store    = w_accept & w_in_range;

    // Statistics restart on dl_start; a write in that same cycle is then
    // applied on top of the cleared values.
    assign w_count_base = w_dl_start ? '0 : r_byte_count;
    assign w_sum_base   = w_dl_start ? '0 : r_checksum;

    always_comb begin
        w_count_next = w_count_base;
        w_sum_next   = w_sum_base;
        if (w_store) begin
            w_sum_next = w_sum_base + {8'd0, ioctl_dout};
            if (w_count_base != c_count_max) begin
                w_count_next = w_count_base + 25'd1;
            end
        end
    end

    assign w_ovf_next = (w_dl_start ? 1'b0 : r_rom_overflow) |
                        (w_accept & ~w_in_range);

    // ------------------------------------------------------------------
    // Sequencing FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_dl_start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_dl_end) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A new download takes priority over finishing the settle.
                if (w_dl_start) begin
                    w_state_next = ST_LOAD;
                end else if (r_settle_cnt == c_settle_last) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (w_dl_start) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, statistics and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_dl_addr      <= '0;
            r_dl_data      <= '0;
            r_dl_wr        <= 1'b0;
            r_core_reset   <= 1'b1;
            r_rom_ready    <= 1'b0;
            r_rom_short    <= 1'b0;
            r_rom_overflow <= 1'b0;
            r_byte_count   <= '0;
            r_checksum     <= '0;
            r_settle_cnt   <= '0;
        end else begin
            // Address and data only move with a strobe, so the RAM side
            // sees stable values around every WR pulse.
            r_dl_wr <= w_store;
            if (w_store) begin
                r_dl_addr <= ioctl_addr;
                r_dl_data <= ioctl_dout;
            end

            r_byte_count   <= w_count_next;
            r_checksum     <= w_sum_next;
            r_rom_overflow <= w_ovf_next;

            // Held at zero for the whole load so SETTLE always starts from
            // zero and lasts exactly SETTLE_CYCLES cycles.
            if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 16'd1;
            end else begin
                r_settle_cnt <= '0;
            end

            // Driven from the next state so the CPUs are released on the
            // same edge the FSM enters READY and re-held on the edge after
            // any dl_start.
            r_core_reset <= (w_state_next != ST_READY);
            r_rom_ready  <= (w_state_next == ST_READY);

            if (w_dl_start) begin
                r_rom_short <= 1'b0;
            end else if ((r_state == ST_SETTLE) && (w_state_next == ST_READY)) begin
                r_rom_short <= (r_byte_count < c_rom_size);
            end
        end
    end

    assign dl_addr      = r_dl_addr;
    assign dl_data      = r_dl_data;
    assign dl_wr        = r_dl_wr;
    assign core_reset   = r_core_reset;
    assign rom_ready    = r_rom_ready;
    assign rom_short    = r_rom_short;
    assign rom_overflow = r_rom_overflow;
    assign byte_count   = r_byte_count;
    assign checksum     = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_rom_download_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rom_download_sequencer
// Description : Self-checking bench for rom_download_sequencer. A small
//               ROM_SIZE keeps a complete image load short. Expected values
//               come from a transaction-level model: running byte count and
//               checksum, overflow flag, expected strobe count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_download_sequencer;

    localparam int ROM_INDEX     = 0;
    localparam int ROM_SIZE      = 300;
    localparam int SETTLE_CYCLES = 16;

    logic        CLK;
    logic        RESET_N;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic        core_reset;
    logic        rom_ready;
    logic        rom_short;
    logic        rom_overflow;
    logic [24:0] byte_count;
    logic [15:0] checksum;

    rom_download_sequencer #(
        .ROM_INDEX     (ROM_INDEX),
        .ROM_SIZE      (ROM_SIZE),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_wr          (dl_wr),
        .core_reset     (core_reset),
        .rom_ready      (rom_ready),
        .rom_short      (rom_short),
        .rom_overflow   (rom_overflow),
        .byte_count     (byte_count),
        .checksum       (checksum)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_count   = 0;
    int m_sum     = 0;
    int m_ovf     = 0;
    int m_loading = 0;
    int m_pulses  = 0;
    int m_last_addr = 0;

    // Every high cycle of dl_wr counts as one strobe; extra or stretched
    // strobes show up as a surplus against the model.
    int seen_pulses = 0;
    always @(negedge CLK) begin
        if (dl_wr === 1'b1) seen_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Apply one write to the model; returns whether a strobe is expected.
    function automatic int model_apply(input int acc, input int a, input int d);
        if (acc == 0) return 0;
        if (a < ROM_SIZE) begin
            m_count++;
            m_sum = (m_sum + d) % 65536;
            m_pulses++;
            m_last_addr = a;
            return 1;
        end
        m_ovf = 1;
        return 0;
    endfunction

    task automatic check_strobe(input string tag, input int exp_wr, input int a, input int d);
        chk({tag, "_wr"}, 32'(dl_wr), 32'(exp_wr));
        if (exp_wr != 0) begin
            chk({tag, "_addr"}, 32'(dl_addr), 32'(a));
            chk({tag, "_data"}, 32'(dl_data), 32'(d));
        end
    endtask

    task automatic do_write(input string tag, input int a, input int d);
        int acc;
        int exp_wr;
        acc = (m_loading != 0 && int'(ioctl_index) == ROM_INDEX) ? 1 : 0;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = 8'(d);
        step();
        ioctl_wr = 1'b0;
        exp_wr = model_apply(acc, a, d);
        check_strobe(tag, exp_wr, a, d);
    endtask

    task automatic start_dl(input string tag, input int idx, input int wr, input int a, input int d);
        int exp_wr;
        ioctl_download = 1'b1;
        ioctl_index    = 8'(idx);
        ioctl_wr       = wr[0];
        ioctl_addr     = 25'(a);
        ioctl_dout     = 8'(d);
        step();
        ioctl_wr = 1'b0;
        exp_wr = 0;
        if (idx == ROM_INDEX) begin
            m_count = 0; m_sum = 0; m_ovf = 0; m_loading = 1;
            exp_wr = model_apply(wr, a, d);
            chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
            chk({tag, "_ready"}, 32'(rom_ready), 32'd0);
            chk({tag, "_count"}, 32'(byte_count), 32'(m_count));
        end
        check_strobe(tag, exp_wr, a, d);
    endtask

    task automatic end_dl(input string tag, input int wr, input int a, input int d);
        int acc;
        int exp_wr;
        int was_loading;
        int n;
        acc = (wr != 0 && m_loading != 0 && int'(ioctl_index) == ROM_INDEX) ? 1 : 0;
        ioctl_download = 1'b0;
        ioctl_wr       = wr[0];
        ioctl_addr     = 25'(a);
        ioctl_dout     = 8'(d);
        step();
        ioctl_wr = 1'b0;
        exp_wr = model_apply(acc, a, d);
        check_strobe(tag, exp_wr, a, d);
        was_loading = m_loading;
        m_loading = 0;
        if (was_loading != 0) begin
            chk({tag, "_held"}, 32'(core_reset), 32'd1);
            n = 0;
            while (rom_ready !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            chk({tag, "_settle_len"}, 32'(n), 32'(SETTLE_CYCLES));
        end
    endtask

    task automatic check_stats(input string tag);
        @(negedge CLK);
        #1;
        chk({tag, "_count"}, 32'(byte_count), 32'(m_count));
        chk({tag, "_sum"}, 32'(checksum), 32'(m_sum));
        chk({tag, "_ovf"}, 32'(rom_overflow), 32'(m_ovf));
        chk({tag, "_pulses"}, 32'(seen_pulses), 32'(m_pulses));
    endtask

    task automatic check_ready(input string tag);
        chk({tag, "_ready"}, 32'(rom_ready), 32'd1);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        chk({tag, "_short"}, 32'(rom_short), (m_count < ROM_SIZE) ? 32'd1 : 32'd0);
    endtask

    task automatic random_writes(input string tag, input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) a = ROM_SIZE + int'($urandom_range(0, 1000));
            else a = int'($urandom_range(0, ROM_SIZE - 1));
            do_write(tag, a, int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        RESET_N        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;

        // Reset and idle
        repeat (2) step();
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_dl_addr", 32'(dl_addr), 32'd0);
        chk("rst_dl_data", 32'(dl_data), 32'd0);
        RESET_N = 1'b1;
        repeat (10) step();
        chk("idle_core_reset", 32'(core_reset), 32'd1);
        chk("idle_ready", 32'(rom_ready), 32'd0);
        chk("idle_short", 32'(rom_short), 32'd0);
        check_stats("idle");

        // Short directed load: 0x01, 0x02, 0xFF at first, second, last address
        start_dl("l1_start", ROM_INDEX, 0, 0, 0);
        do_write("l1_b0", 0, 'h01);
        step();
        do_write("l1_b1", 1, 'h02);
        step(); step();
        do_write("l1_b2", ROM_SIZE - 1, 'hFF);
        end_dl("l1_end", 0, 0, 0);
        check_ready("l1");
        check_stats("l1");
        chk("l1_sum_value", 32'(checksum), 32'h0102);

        // Full image of 0x01 plus one out-of-range byte, all back to back
        start_dl("full_start", ROM_INDEX, 1, 0, 'h01);
        for (int a = 1; a < ROM_SIZE; a++) do_write("full", a, 'h01);
        do_write("full_over", ROM_SIZE, 'h01);
        end_dl("full_end", 0, 0, 0);
        check_ready("full");
        check_stats("full");
        chk("full_count_value", 32'(byte_count), 32'(ROM_SIZE));
        chk("full_last_addr", 32'(dl_addr), 32'(ROM_SIZE - 1));

        // Foreign index while READY, plus index-0 writes with no download
        start_dl("idx1_start", 1, 1, 5, 'h55);
        random_writes("idx1", 12);
        end_dl("idx1_end", 1, 7, 'h77);
        ioctl_index = 8'(ROM_INDEX);
        do_write("nodl", 3, 'h33);
        repeat (SETTLE_CYCLES + 4) step();
        check_ready("idx1");
        check_stats("idx1");

        // Reload from READY with writes in the start and end cycles
        start_dl("re_start", ROM_INDEX, 1, 10, int'($urandom_range(0, 255)));
        random_writes("re", 40);
        end_dl("re_end", 1, 11, int'($urandom_range(0, 255)));
        check_ready("re");
        check_stats("re");

        // Reset in the middle of a load at byte 100
        start_dl("rl_start", ROM_INDEX, 0, 0, 0);
        for (int a = 0; a < 100; a++) do_write("rl", a, int'($urandom_range(0, 255)));
        RESET_N    = 1'b0;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd100;
        ioctl_dout = 8'hA5;
        step();
        RESET_N  = 1'b1;
        ioctl_wr = 1'b0;
        m_count = 0; m_sum = 0; m_ovf = 0; m_loading = 0;
        chk("rl_dl_wr", 32'(dl_wr), 32'd0);
        chk("rl_count", 32'(byte_count), 32'd0);
        chk("rl_core_reset", 32'(core_reset), 32'd1);
        chk("rl_ready", 32'(rom_ready), 32'd0);
        for (int a = 101; a < 106; a++) do_write("rl_after", a, 'h11);
        ioctl_download = 1'b0;
        repeat (SETTLE_CYCLES + 10) step();
        chk("rl_idle_ready", 32'(rom_ready), 32'd0);
        chk("rl_idle_core_reset", 32'(core_reset), 32'd1);
        check_stats("rl");

        // Recovery load after the abort
        start_dl("rc_start", ROM_INDEX, 1, 0, int'($urandom_range(0, 255)));
        random_writes("rc", 20);
        end_dl("rc_end", 1, ROM_SIZE - 2, int'($urandom_range(0, 255)));
        check_ready("rc");
        check_stats("rc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
